// File: rtl/sbox_forward_iterative.sv
// Serial AES forward S-box: one byte per 7 cycles (a^254 via repeated squaring, then affine), result 7*NBYTES cycles after accept.
// One word in flight; in_ready low in MUL/OUT, result held in OUT until out_ready.
module sbox_forward_iterative #(
   parameter int NBYTES = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [8*NBYTES-1:0] in_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [8*NBYTES-1:0] out_data,
   output logic                busy
);
   localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_OUT} state_t;

   state_t              state_q, state_d;
   logic [8*NBYTES-1:0] word_q, word_d;
   logic [8*NBYTES-1:0] res_q, res_d;
   logic [7:0]          b_q, b_d;
   logic [7:0]          r_q, r_d;
   logic [2:0]          iter_q, iter_d;
   logic [KW-1:0]       k_q, k_d;
   logic [KW-1:0]       k_nxt;
   logic [7:0]          a_nxt;
   logic [7:0]          rb, bb;

   function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = 8'h00;
      sh  = x;
      for (int i = 0; i < 8; i++) begin
         if (y[i]) acc = acc ^ sh;
         sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1B : 8'h00);
      end
      return acc;
   endfunction

   function automatic logic [7:0] affine(input logic [7:0] r);
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   assign rb    = gf_mul(r_q, b_q);
   assign bb    = gf_mul(b_q, b_q);
   assign k_nxt = k_q + KW'(1);

   // Byte mux for the next operand; loop form avoids an oversized dynamic index.
   always_comb begin
      a_nxt = 8'h00;
      for (int i = 0; i < NBYTES; i++) begin
         if (KW'(i) == k_nxt) a_nxt = word_q[8*i +: 8];
      end
   end

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      res_d   = res_q;
      b_d     = b_q;
      r_d     = r_q;
      iter_d  = iter_q;
      k_d     = k_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               word_d  = in_data;
               k_d     = '0;
               b_d     = gf_mul(in_data[7:0], in_data[7:0]);
               r_d     = 8'h01;
               iter_d  = 3'd0;
               state_d = S_MUL;
            end
         end
         S_MUL: begin
            if (iter_q != 3'd6) begin
               r_d    = rb;
               b_d    = bb;
               iter_d = iter_q + 3'd1;
            end else begin
               // Seventh product folds straight into the affine and the result byte.
               for (int i = 0; i < NBYTES; i++) begin
                  if (KW'(i) == k_q) res_d[8*i +: 8] = affine(rb);
               end
               if (int'(k_q) < NBYTES - 1) begin
                  k_d    = k_nxt;
                  b_d    = gf_mul(a_nxt, a_nxt);
                  r_d    = 8'h01;
                  iter_d = 3'd0;
               end else begin
                  state_d = S_OUT;
               end
            end
         end
         S_OUT: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         word_q  <= '0;
         res_q   <= '0;
         b_q     <= 8'h00;
         r_q     <= 8'h00;
         iter_q  <= 3'd0;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         res_q   <= res_d;
         b_q     <= b_d;
         r_q     <= r_d;
         iter_q  <= iter_d;
         k_q     <= k_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_OUT);
   assign busy      = (state_q == S_MUL);
   assign out_data  = res_q;

endmodule

// File: tb/tb_sbox_forward_iterative.sv
// Bench for sbox_forward_iterative: a 4-byte and a 1-byte instance, scoreboarded against a log/antilog S-box model.
module tb_sbox_forward_iterative;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic        iv4, ir4, ov4, or4, busy4;
   logic [31:0] id4, od4;
   logic        iv1, ir1, ov1, or1, busy1;
   logic [7:0]  id1, od1;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [7:0]  sbox [256];
   logic [7:0]  ex_t [256];
   int          lg_t [256];
   logic [31:0] exp4_q [$];
   int          acc4_q [$];
   int          acc4_log [$];
   logic [7:0]  exp1_q [$];
   int          acc1_q [$];

   sbox_forward_iterative #(.NBYTES(4)) u_dut4 (
      .clk(clk), .reset_n(reset_n), .in_valid(iv4), .in_ready(ir4), .in_data(id4),
      .out_valid(ov4), .out_ready(or4), .out_data(od4), .busy(busy4));

   sbox_forward_iterative #(.NBYTES(1)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
      .out_valid(ov1), .out_ready(or1), .out_data(od1), .busy(busy1));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   function automatic logic [7:0] xt(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
   endfunction

   // Inverse from generator-3 log/antilog tables, affine from the bitwise form.
   task automatic build_model();
      logic [7:0] x, inv, s, c;
      x = 8'h01;
      c = 8'h63;
      for (int i = 0; i < 255; i++) begin
         ex_t[i] = x;
         lg_t[x] = i;
         x = x ^ xt(x);
      end
      for (int a = 0; a < 256; a++) begin
         inv = (a == 0) ? 8'h00 : ex_t[(255 - lg_t[a]) % 255];
         for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
         sbox[a] = s;
      end
   endtask

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      logic [31:0] r;
      for (int k = 0; k < 4; k++) r[8*k +: 8] = sbox[w[8*k +: 8]];
      return r;
   endfunction

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!reset_n) begin
         exp4_q.delete(); acc4_q.delete(); exp1_q.delete(); acc1_q.delete();
      end else begin
         if (iv4 && ir4) begin
            exp4_q.push_back(sub_word(id4));
            acc4_q.push_back(cyc + 1);
            acc4_log.push_back(cyc + 1);
         end
         if (iv1 && ir1) begin
            exp1_q.push_back(sbox[id1]);
            acc1_q.push_back(cyc + 1);
         end
      end
   end

   logic        ov4_prev = 1'b0, ov1_prev = 1'b0;
   logic [31:0] held4;
   logic [7:0]  held1;
   int          bcnt4 = 0, bcnt1 = 0;

   always @(negedge clk) begin
      if (!reset_n) begin
         ov4_prev = 1'b0;
         bcnt4    = 0;
      end else begin
         if (busy4) bcnt4++;
         if (ov4 && !ov4_prev) begin
            if (exp4_q.size() == 0) chk("spurious_out4", exp4_q.size(), 1);
            else begin
               chk("data4", od4, exp4_q[0]);
               chk("latency4", cyc - acc4_q[0], 28);
               chk("busy_cycles4", bcnt4, 28);
            end
            held4 = od4;
            bcnt4 = 0;
         end else if (ov4) chk("hold4", od4, held4);
         if (ov4 && or4 && exp4_q.size() != 0) begin
            void'(exp4_q.pop_front());
            void'(acc4_q.pop_front());
         end
         ov4_prev = ov4;
      end
   end

   always @(negedge clk) begin
      if (!reset_n) begin
         ov1_prev = 1'b0;
         bcnt1    = 0;
      end else begin
         if (busy1) bcnt1++;
         if (ov1 && !ov1_prev) begin
            if (exp1_q.size() == 0) chk("spurious_out1", exp1_q.size(), 1);
            else begin
               chk("data1", {24'h0, od1}, {24'h0, exp1_q[0]});
               chk("latency1", cyc - acc1_q[0], 7);
               chk("busy_cycles1", bcnt1, 7);
            end
            held1 = od1;
            bcnt1 = 0;
         end else if (ov1) chk("hold1", {24'h0, od1}, {24'h0, held1});
         if (ov1 && or1 && exp1_q.size() != 0) begin
            void'(exp1_q.pop_front());
            void'(acc1_q.pop_front());
         end
         ov1_prev = ov1;
      end
   end

   task automatic send4(input logic [31:0] w);
      int n;
      n   = 0;
      iv4 = 1'b1;
      id4 = w;
      while (!ir4 && n < 200) begin @(negedge clk); n++; end
      if (!ir4) chk("send4_timeout", {31'h0, ir4}, 1);
      @(negedge clk);
      iv4 = 1'b0;
      id4 = $urandom;
   endtask

   task automatic get4(input string name, input logic [31:0] expv);
      int n;
      n = 0;
      while (!ov4 && n < 500) begin @(negedge clk); n++; end
      if (!ov4) chk({name, "_timeout"}, {31'h0, ov4}, 1);
      else chk(name, od4, expv);
      @(negedge clk);
   endtask

   task automatic drain4();
      int n;
      n = 0;
      while (exp4_q.size() != 0 && n < 3000) begin @(negedge clk); n++; end
      if (exp4_q.size() != 0) chk("drain4_timeout", exp4_q.size(), 0);
   endtask

   logic rand_done = 1'b0;

   initial begin
      int n, s0, h;
      build_model();
      reset_n = 1'b0;
      iv4 = 1'b0; id4 = '0; or4 = 1'b0;
      iv1 = 1'b0; id1 = '0; or1 = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", {31'h0, ir4}, 1);
      chk("rst_out_valid", {31'h0, ov4}, 0);
      chk("rst_busy", {31'h0, busy4}, 0);
      chk("rst_out_data", od4, 0);
      chk("rst_out_data1", {24'h0, od1}, 0);
      reset_n = 1'b1;
      @(negedge clk);

      or4 = 1'b1;
      send4(32'h53520100); get4("vec_53520100", 32'hED007C63);
      send4(32'hCF4F3C09); get4("vec_cf4f3c09", 32'h8A84EB01);
      send4(32'hFFFFFFFF); get4("vec_ffffffff", 32'h16161616);

      // Exhaustive single-byte sweep with in_valid held high.
      for (int a = 0; a < 256; a++) begin
         iv1 = 1'b1;
         id1 = 8'(a);
         n = 0;
         while (!ir1 && n < 100) begin @(negedge clk); n++; end
         if (!ir1) chk("sweep_timeout", {31'h0, ir1}, 1);
         @(negedge clk);
      end
      iv1 = 1'b0;
      n = 0;
      while (exp1_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
      chk("sweep_drained", exp1_q.size(), 0);

      // Long output stall with in_valid high and changing data.
      or4 = 1'b0;
      send4($urandom);
      n = 0;
      while (!ov4 && n < 100) begin @(negedge clk); n++; end
      s0 = acc4_log.size();
      iv4 = 1'b1;
      for (int i = 0; i < 50; i++) begin
         id4 = $urandom;
         @(negedge clk);
         chk("stall_in_ready", {31'h0, ir4}, 0);
         chk("stall_out_valid", {31'h0, ov4}, 1);
      end
      chk("stall_no_accept", acc4_log.size(), s0);
      or4 = 1'b1;
      @(negedge clk);
      h = cyc;
      or4 = 1'b0;
      chk("release_in_ready", {31'h0, ir4}, 1);
      @(negedge clk);
      iv4 = 1'b0;
      chk("release_accept_edge", acc4_log[$], h + 1);
      or4 = 1'b1;
      drain4();

      // Reset during the tenth MUL cycle.
      send4($urandom);
      repeat (9) @(negedge clk);
      chk("pre_reset_busy", {31'h0, busy4}, 1);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      chk("midrst_out_valid", {31'h0, ov4}, 0);
      chk("midrst_out_data", od4, 0);
      chk("midrst_in_ready", {31'h0, ir4}, 1);
      chk("midrst_busy", {31'h0, busy4}, 0);
      send4(32'h00000000); get4("after_reset_zero", 32'h63636363);

      // Back-to-back: accept edges 30 apart (29 non-accept cycles in between).
      s0 = acc4_log.size();
      iv4 = 1'b1;
      id4 = $urandom;
      n = 0;
      while (acc4_log.size() < s0 + 3 && n < 200) begin
         h = acc4_log.size();
         @(negedge clk);
         if (acc4_log.size() != h) id4 = $urandom;
         n++;
      end
      iv4 = 1'b0;
      if (acc4_log.size() < s0 + 3) chk("b2b_timeout", acc4_log.size(), s0 + 3);
      else begin
         chk("b2b_gap1", acc4_log[s0+1] - acc4_log[s0], 30);
         chk("b2b_gap2", acc4_log[s0+2] - acc4_log[s0+1], 30);
      end
      drain4();

      // Random words with random gaps and random out_ready.
      fork
         begin
            for (int i = 0; i < 20; i++) begin
               repeat ($urandom_range(0, 3)) @(negedge clk);
               send4($urandom);
            end
            drain4();
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(negedge clk);
               or4 = ($urandom_range(0, 3) != 0);
            end
         end
      join
      or4 = 1'b1;
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      bad++;
      $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

endmodule
